// File: rtl/uart_tx_fifo_if.sv
// Byte write port of the UART transmitter: valid/ready handshake.
`timescale 1ns/1ps
interface uart_tx_fifo_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  // Producer side drives data/valid and watches ready.
  modport master (output tx_data, output tx_valid, input tx_ready);
  // Transmitter side consumes data/valid and reports ready.
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter, LSB first, fed by a small circular byte FIFO.
// Queued bytes go out back-to-back with no idle gap between frames.
`timescale 1ns/1ps
module uart_tx_fifo #(
  parameter int BAUDRATE       = 115_200,
  parameter int BASE_CLK       = 50_000_000,
  parameter int CLOCKS_PER_BIT = BASE_CLK / BAUDRATE,
  parameter int FIFO_DEPTH     = 4,
  localparam int CW            = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_fifo_if.slave     wr,
  output logic              serial_data_out,
  output logic              tx_busy,
  output logic [CW-1:0]     fifo_count
);

  localparam int          AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [31:0] CPB_LAST = 32'(CLOCKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop, bit_done;

  state_t        state;
  logic [31:0]   ctr;
  logic [2:0]    idx;
  logic [7:0]    shreg;

  // Ready comes from the registered count, so a full FIFO never admits a
  // push even on an edge where the FSM pops.
  assign wr.tx_ready = (count != CW'(FIFO_DEPTH));
  assign push        = wr.tx_valid & wr.tx_ready;
  assign bit_done    = (ctr == CPB_LAST);
  // Pop whenever a new frame is launched: from IDLE, or straight out of STOP.
  assign pop         = (count != '0) && ((state == IDLE) || (state == STOP && bit_done));

  assign tx_busy     = (state != IDLE) || (count != '0);
  assign fifo_count  = count;

  // FIFO storage: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr.tx_data;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at power-of-2 depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Frame FSM: the byte is captured into shreg at pop, so later writes
  // cannot disturb the frame on the line. Line output is registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      serial_data_out <= 1'b1;
      ctr             <= '0;
      idx             <= '0;
      shreg           <= '0;
    end else begin
      case (state)
        IDLE: begin
          serial_data_out <= 1'b1;
          ctr             <= '0;
          if (pop) begin
            shreg           <= mem[rd_ptr];
            serial_data_out <= 1'b0;
            state           <= START;
          end
        end
        START: begin
          if (bit_done) begin
            serial_data_out <= shreg[0];
            idx             <= '0;
            ctr             <= '0;
            state           <= DATA;
          end else begin
            ctr <= ctr + 32'd1;
          end
        end
        DATA: begin
          if (bit_done) begin
            ctr <= '0;
            if (idx != 3'd7) begin
              // shreg[0] is the bit on the line; shift so shreg[1] is next.
              idx             <= idx + 3'd1;
              serial_data_out <= shreg[1];
              shreg           <= {1'b0, shreg[7:1]};
            end else begin
              serial_data_out <= 1'b1;
              state           <= STOP;
            end
          end else begin
            ctr <= ctr + 32'd1;
          end
        end
        STOP: begin
          if (bit_done) begin
            ctr <= '0;
            if (pop) begin
              shreg           <= mem[rd_ptr];
              serial_data_out <= 1'b0;
              state           <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            ctr <= ctr + 32'd1;
          end
        end
        default: begin
          state           <= IDLE;
          serial_data_out <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a serial-line decoder and a byte scoreboard.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       serial_data_out;
  logic       tx_busy;
  logic [2:0] fifo_count;

  uart_tx_fifo_if wr_if();

  uart_tx_fifo #(.BAUDRATE(1), .BASE_CLK(16), .FIFO_DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .wr             (wr_if.slave),
    .serial_data_out(serial_data_out),
    .tx_busy        (tx_busy),
    .fifo_count     (fifo_count)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         frames = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for the transmitter to go idle.
  task automatic wait_idle(input string tag, input int limit);
    int n = 0;
    while (tx_busy === 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(tx_busy), 0);
  endtask

  // Line decoder: detect start edge, sample mid-bit (16 clocks/bit), check
  // framing and compare the byte against the scoreboard head.
  initial begin
    logic       prev_line = 1'b1;
    logic       act = 1'b0;
    int         cnt = 0;
    logic [7:0] sh = '0;
    logic [7:0] exp_b;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        act = 1'b0;
      end else if (!act) begin
        if (prev_line && serial_data_out === 1'b0) begin
          act = 1'b1;
          cnt = 0;
        end
      end else begin
        cnt++;
        if (cnt == 8) begin
          chk("start_bit", 32'(serial_data_out), 0);
        end else if (cnt > 8 && cnt < 152 && (cnt - 8) % 16 == 0) begin
          sh = {serial_data_out, sh[7:1]};
        end else if (cnt == 152) begin
          chk("stop_bit", 32'(serial_data_out), 1);
          frames++;
          chk("frame_queued", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            exp_b = exp_q.pop_front();
            chk("rx_byte", 32'(sh), 32'(exp_b));
          end
          act = 1'b0;
        end
      end
      prev_line = serial_data_out;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    rst = 1'b1;
    wr_if.tx_valid = 1'b0;
    wr_if.tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_line",  32'(serial_data_out), 1);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_ready", 32'(wr_if.tx_ready), 1);
    chk("rst_busy",  32'(tx_busy), 0);
    rst = 1'b0;

    // Idle hold: nothing written for 1000 clocks.
    ok = 1'b1;
    repeat (1000) begin
      @(negedge clk);
      if (serial_data_out !== 1'b1 || tx_busy !== 1'b0 || wr_if.tx_ready !== 1'b1) ok = 1'b0;
    end
    chk("idle_hold", 32'(ok), 1);

    // Single byte 0xA5: start edge one clock after the write, 160-clock frame.
    wr_if.tx_data = 8'hA5; wr_if.tx_valid = 1'b1; exp_q.push_back(8'hA5);
    @(negedge clk); wr_if.tx_valid = 1'b0;
    chk("t1_count_written", 32'(fifo_count), 1);
    chk("t1_line_pre",      32'(serial_data_out), 1);
    chk("t1_busy",          32'(tx_busy), 1);
    @(negedge clk);
    chk("t1_count_popped",  32'(fifo_count), 0);
    chk("t1_start_edge",    32'(serial_data_out), 0);
    repeat (15) @(negedge clk);
    chk("t1_start_end",     32'(serial_data_out), 0);
    @(negedge clk);
    chk("t1_bit0",          32'(serial_data_out), 1);
    repeat (143) @(negedge clk);
    chk("t1_busy_last",     32'(tx_busy), 1);
    @(negedge clk);
    chk("t1_busy_drop",     32'(tx_busy), 0);

    // Two bytes on consecutive cycles: contiguous 320-clock burst.
    wr_if.tx_data = 8'h55; wr_if.tx_valid = 1'b1; exp_q.push_back(8'h55);
    @(negedge clk);
    wr_if.tx_data = 8'h0F; exp_q.push_back(8'h0F);
    @(negedge clk); wr_if.tx_valid = 1'b0;
    repeat (159) @(negedge clk);
    chk("t2_stop_line",   32'(serial_data_out), 1);
    chk("t2_count_mid",   32'(fifo_count), 1);
    @(negedge clk);
    chk("t2_no_gap",      32'(serial_data_out), 0);
    chk("t2_count_pop",   32'(fifo_count), 0);
    repeat (159) @(negedge clk);
    chk("t2_busy_last",   32'(tx_busy), 1);
    @(negedge clk);
    chk("t2_busy_drop",   32'(tx_busy), 0);

    // Six back-to-back writes: byte0 pops, bytes1-4 fill, byte5 dropped.
    for (int i = 0; i < 6; i++) begin
      if (i == 5) begin
        chk("t3_full_count", 32'(fifo_count), 4);
        chk("t3_full_ready", 32'(wr_if.tx_ready), 0);
      end
      wr_if.tx_data = 8'(8'h10 + i); wr_if.tx_valid = 1'b1;
      if (i < 5) exp_q.push_back(8'(8'h10 + i));
      @(negedge clk);
    end
    wr_if.tx_valid = 1'b0;
    chk("t3_drop_count", 32'(fifo_count), 4);
    wait_idle("t3_drain", 1000);
    chk("t3_q_empty", 32'(exp_q.size()), 0);

    // Full FIFO, valid held across the pop edge: accepted one edge later.
    for (int i = 0; i < 5; i++) begin
      wr_if.tx_data = 8'(8'h20 + i); wr_if.tx_valid = 1'b1;
      exp_q.push_back(8'(8'h20 + i));
      @(negedge clk);
    end
    wr_if.tx_data = 8'h2F;
    repeat (156) @(negedge clk);
    chk("t4_full_count",   32'(fifo_count), 4);
    chk("t4_full_ready",   32'(wr_if.tx_ready), 0);
    @(negedge clk);
    chk("t4_pop_count",    32'(fifo_count), 3);
    chk("t4_pop_ready",    32'(wr_if.tx_ready), 1);
    @(negedge clk);
    chk("t4_push_count",   32'(fifo_count), 4);
    wr_if.tx_valid = 1'b0; exp_q.push_back(8'h2F);
    wait_idle("t4_drain", 1000);
    chk("t4_q_empty", 32'(exp_q.size()), 0);

    // Reset mid-frame of 0xC3 with 0x99 queued: both abandoned.
    wr_if.tx_data = 8'hC3; wr_if.tx_valid = 1'b1;
    @(negedge clk);
    wr_if.tx_data = 8'h99;
    @(negedge clk); wr_if.tx_valid = 1'b0;
    repeat (55) @(negedge clk);
    chk("t5_line_pre_rst",  32'(serial_data_out), 0);
    chk("t5_count_pre_rst", 32'(fifo_count), 1);
    rst = 1'b1;
    #1;
    chk("t5_rst_line",  32'(serial_data_out), 1);
    chk("t5_rst_count", 32'(fifo_count), 0);
    chk("t5_rst_busy",  32'(tx_busy), 0);
    chk("t5_rst_ready", 32'(wr_if.tx_ready), 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_post_line", 32'(serial_data_out), 1);
    wr_if.tx_data = 8'h3C; wr_if.tx_valid = 1'b1; exp_q.push_back(8'h3C);
    @(negedge clk); wr_if.tx_valid = 1'b0;
    wait_idle("t5_drain", 400);
    repeat (4) @(negedge clk);
    chk("t5_q_empty",   32'(exp_q.size()), 0);
    chk("frame_total",  32'(frames), 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
